k_and_s_control_unit: RTL and testbench

Moore-style FSM that sequences the K&S data_path through fetch, decode and execute for every instruction. It drives all datapath control strobes and the RAM write strobe. It consumes the decoded instruction and the registered ALU flags from the datapath. It sits beside data_path inside the processor top level and shares clk with it.

---
 rtl/k_and_s_control_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_k_and_s_control_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/k_and_s_control_unit.sv
// K&S processor control unit: Moore FSM sequencing fetch, decode and execute.
// Drives every datapath control strobe and the RAM write strobe.
// Optional build macro K_AND_S_PERF_CNT_EN adds the instr_count and
// cycle_count performance counter outputs.

package k_and_s_pkg;
    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_HALT   = 5'd15
    } decoded_instruction_type;
endpackage

module k_and_s_control_unit
    import k_and_s_pkg::*;
#(
    parameter int MEM_WAIT = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
`ifdef K_AND_S_PERF_CNT_EN
    output logic [15:0]             instr_count,
    output logic [15:0]             cycle_count,
`endif
    output logic                    halt
);

    typedef enum logic [2:0] {
        S_FETCH       = 3'd0,
        S_DECODE      = 3'd1,
        S_EXEC_LOAD   = 3'd2,
        S_EXEC_STORE  = 3'd3,
        S_EXEC_MOVE   = 3'd4,
        S_EXEC_ALU    = 3'd5,
        S_EXEC_BRANCH = 3'd6,
        S_HALTED      = 3'd7
    } state_t;

    // Wait counter value marking the final cycle of a memory access
    localparam logic [2:0] LP_LAST = 3'(MEM_WAIT);

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_wcnt;
    logic [2:0] w_wcnt_next;
    logic       w_mem_last;
    logic       w_taken;

    // Reserved flag, carried for interface compatibility only
    logic       w_unused_sig;
    assign w_unused_sig = signed_overflow;

    assign w_mem_last = (r_wcnt == LP_LAST);

    // Branch condition evaluated from the registered ALU flags
    always_comb begin
        w_taken = 1'b0;
        case (decoded_instruction)
            I_BRANCH: w_taken = 1'b1;
            I_BZERO:  w_taken = zero_op;
            I_BNZERO: w_taken = ~zero_op;
            I_BNEG:   w_taken = neg_op;
            I_BNNEG:  w_taken = ~neg_op;
            I_BOV:    w_taken = unsigned_overflow;
            I_BNOV:   w_taken = ~unsigned_overflow;
            default:  w_taken = 1'b0;
        endcase
    end

    // State and wait counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_wcnt  <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_wcnt  <= w_wcnt_next;
        end
    end

    // Next-state and Moore output decode; reset forces every output low
    always_comb begin
        w_next_state     = r_state;
        w_wcnt_next      = 3'd0;
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = 2'b00;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;

        case (r_state)
            S_FETCH: begin
                addr_sel = 1'b0;
                if (w_mem_last) begin
                    ir_enable    = 1'b1;
                    w_next_state = S_DECODE;
                end else begin
                    w_wcnt_next = r_wcnt + 3'd1;
                end
            end
            S_DECODE: begin
                pc_enable = 1'b1;
                case (decoded_instruction)
                    I_LOAD:  w_next_state = S_EXEC_LOAD;
                    I_STORE: w_next_state = S_EXEC_STORE;
                    I_MOVE:  w_next_state = S_EXEC_MOVE;
                    I_ADD, I_SUB, I_AND, I_OR:
                             w_next_state = S_EXEC_ALU;
                    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
                             w_next_state = S_EXEC_BRANCH;
                    I_HALT:  w_next_state = S_HALTED;
                    default: w_next_state = S_FETCH;
                endcase
            end
            S_EXEC_LOAD: begin
                addr_sel = 1'b1;
                c_sel    = 1'b0;
                if (w_mem_last) begin
                    write_reg_enable = 1'b1;
                    w_next_state     = S_FETCH;
                end else begin
                    w_wcnt_next = r_wcnt + 3'd1;
                end
            end
            S_EXEC_STORE: begin
                addr_sel         = 1'b1;
                ram_write_enable = 1'b1;
                w_next_state     = S_FETCH;
            end
            S_EXEC_MOVE: begin
                operation        = 2'b11;
                c_sel            = 1'b1;
                write_reg_enable = 1'b1;
                w_next_state     = S_FETCH;
            end
            S_EXEC_ALU: begin
                c_sel            = 1'b1;
                write_reg_enable = 1'b1;
                flags_reg_enable = 1'b1;
                case (decoded_instruction)
                    I_SUB:   operation = 2'b01;
                    I_AND:   operation = 2'b10;
                    I_OR:    operation = 2'b11;
                    default: operation = 2'b00;
                endcase
                w_next_state = S_FETCH;
            end
            S_EXEC_BRANCH: begin
                branch       = 1'b1;
                pc_enable    = w_taken;
                w_next_state = S_FETCH;
            end
            S_HALTED: begin
                halt         = 1'b1;
                w_next_state = S_HALTED;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase

        if (rst) begin
            branch           = 1'b0;
            pc_enable        = 1'b0;
            ir_enable        = 1'b0;
            addr_sel         = 1'b0;
            c_sel            = 1'b0;
            operation        = 2'b00;
            write_reg_enable = 1'b0;
            flags_reg_enable = 1'b0;
            ram_write_enable = 1'b0;
            halt             = 1'b0;
        end
    end

`ifdef K_AND_S_PERF_CNT_EN
    logic [15:0] r_instr_count;
    logic [15:0] r_cycle_count;

    // Performance counters: cycles run until halt, instructions decoded
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_count <= 16'd0;
            r_cycle_count <= 16'd0;
        end else begin
            if (r_state != S_HALTED) begin
                r_cycle_count <= r_cycle_count + 16'd1;
            end
            if (r_state == S_DECODE) begin
                r_instr_count <= r_instr_count + 16'd1;
            end
        end
    end

    assign instr_count = r_instr_count;
    assign cycle_count = r_cycle_count;
`endif

endmodule

// File: tb/tb_k_and_s_control_unit.sv
// Self-checking bench for k_and_s_control_unit: two instances (MEM_WAIT 1 and 3)
// checked cycle by cycle against a per-instruction expected-output model.
module tb_k_and_s_control_unit;
    import k_and_s_pkg::*;

    // Output vector layout:
    // [10]halt [9]branch [8]pc_enable [7]ir_enable [6]addr_sel [5]c_sel
    // [4:3]operation [2]write_reg_enable [1]flags_reg_enable [0]ram_write_enable
    typedef logic [10:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    decoded_instruction_type instr = I_NOP;
    logic zf = 1'b0;
    logic nf = 1'b0;
    logic uf = 1'b0;
    logic sf = 1'b0;

    logic br1, pc1, ir1, as1, cs1, wr1, fr1, rw1, h1;
    logic [1:0] op1;
    logic br3, pc3, ir3, as3, cs3, wr3, fr3, rw3, h3;
    logic [1:0] op3;
`ifdef K_AND_S_PERF_CNT_EN
    logic [15:0] ic1, cc1, ic3, cc3;
`endif

    always #5 clk = ~clk;

    k_and_s_control_unit #(.MEM_WAIT(1)) dut1 (
        .clk(clk), .rst(rst), .decoded_instruction(instr),
        .zero_op(zf), .neg_op(nf), .unsigned_overflow(uf), .signed_overflow(sf),
        .branch(br1), .pc_enable(pc1), .ir_enable(ir1), .addr_sel(as1),
        .c_sel(cs1), .operation(op1), .write_reg_enable(wr1),
        .flags_reg_enable(fr1), .ram_write_enable(rw1),
`ifdef K_AND_S_PERF_CNT_EN
        .instr_count(ic1), .cycle_count(cc1),
`endif
        .halt(h1)
    );

    k_and_s_control_unit #(.MEM_WAIT(3)) dut3 (
        .clk(clk), .rst(rst), .decoded_instruction(instr),
        .zero_op(zf), .neg_op(nf), .unsigned_overflow(uf), .signed_overflow(sf),
        .branch(br3), .pc_enable(pc3), .ir_enable(ir3), .addr_sel(as3),
        .c_sel(cs3), .operation(op3), .write_reg_enable(wr3),
        .flags_reg_enable(fr3), .ram_write_enable(rw3),
`ifdef K_AND_S_PERF_CNT_EN
        .instr_count(ic3), .cycle_count(cc3),
`endif
        .halt(h3)
    );

    vec_t act1, act3;
    assign act1 = {h1, br1, pc1, ir1, as1, cs1, op1, wr1, fr1, rw1};
    assign act3 = {h3, br3, pc3, ir3, as3, cs3, op3, wr3, fr3, rw3};

    int   errs   = 0;
    int   checks = 0;
    vec_t q1[$];
    vec_t q3[$];
    bit   sel3   = 1'b0;
    int   mw     = 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic vec_t v(input bit h, input bit b, input bit pc, input bit ir,
                               input bit as, input bit cs, input logic [1:0] op,
                               input bit wr, input bit fr, input bit rw);
        return {h, b, pc, ir, as, cs, op, wr, fr, rw};
    endfunction

    function automatic bit taken(input decoded_instruction_type i,
                                 input bit z, input bit n, input bit u);
        case (i)
            I_BRANCH: return 1'b1;
            I_BZERO:  return z;
            I_BNZERO: return !z;
            I_BNEG:   return n;
            I_BNNEG:  return !n;
            I_BOV:    return u;
            I_BNOV:   return !u;
            default:  return 1'b0;
        endcase
    endfunction

    task automatic push(input vec_t x);
        if (sel3) q3.push_back(x);
        else      q1.push_back(x);
    endtask

    function automatic int qsize();
        return sel3 ? q3.size() : q1.size();
    endfunction

    // Fetch occupies MEM_WAIT+1 cycles with IR capture in the last; decode bumps PC
    task automatic model_front();
        for (int c = 0; c <= mw; c++) push(v(0, 0, 0, c == mw, 0, 0, 2'b00, 0, 0, 0));
        push(v(0, 0, 1, 0, 0, 0, 2'b00, 0, 0, 0));
    endtask

    task automatic model_exec(input decoded_instruction_type i, input bit z, input bit n, input bit u);
        case (i)
            I_LOAD:  for (int c = 0; c <= mw; c++) push(v(0, 0, 0, 0, 1, 0, 2'b00, c == mw, 0, 0));
            I_STORE: push(v(0, 0, 0, 0, 1, 0, 2'b00, 0, 0, 1));
            I_MOVE:  push(v(0, 0, 0, 0, 0, 1, 2'b11, 1, 0, 0));
            I_ADD:   push(v(0, 0, 0, 0, 0, 1, 2'b00, 1, 1, 0));
            I_SUB:   push(v(0, 0, 0, 0, 0, 1, 2'b01, 1, 1, 0));
            I_AND:   push(v(0, 0, 0, 0, 0, 1, 2'b10, 1, 1, 0));
            I_OR:    push(v(0, 0, 0, 0, 0, 1, 2'b11, 1, 1, 0));
            I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
                     push(v(0, 1, taken(i, z, n, u), 0, 0, 0, 2'b00, 0, 0, 0));
            default: ;
        endcase
    endtask

    // Wait until the compare process has consumed every queued expectation
    task automatic drain();
        int guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (qsize() > 0 && guard < 200);
        if (qsize() > 0) begin
            checks++;
            errs++;
            $display("FAIL drain_timeout: got %0d pending expected 0", qsize());
            q1.delete();
            q3.delete();
        end
    endtask

    task automatic run_instr(input decoded_instruction_type i, input bit z, input bit n,
                             input bit u, input int exp_len);
        instr = i; zf = z; nf = n; uf = u;
        model_front();
        model_exec(i, z, n, u);
        if (exp_len >= 0) check("model_len", qsize(), exp_len);
        drain();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int c = 0; c < n; c++) push('0);
        drain();
        rst = 1'b0;
    endtask

    // Compare process: every negedge, check each instance with pending expectations
    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("dut1_outputs", act1, e);
                check("dut1_excl", $countones({wr1, rw1, ir1}) <= 1, 1);
            end
            if (q3.size() > 0) begin
                e = q3.pop_front();
                check("dut3_outputs", act3, e);
                check("dut3_excl", $countones({wr3, rw3, ir3}) <= 1, 1);
            end
        end
    end

    initial begin
        decoded_instruction_type unk;
        unk = decoded_instruction_type'(5'd20);
        @(posedge clk);
        #1;
        sel3 = 1'b0;
        mw = 1;
        do_reset(2);

        run_instr(I_ADD,    0, 0, 0, 4);
        run_instr(I_SUB,    0, 0, 0, 4);
        run_instr(I_AND,    0, 0, 0, -1);
        run_instr(I_OR,     0, 0, 0, -1);
        run_instr(I_MOVE,   0, 0, 0, 4);
        run_instr(I_STORE,  0, 0, 0, 4);
        run_instr(I_LOAD,   0, 0, 0, 5);
        run_instr(I_NOP,    0, 0, 0, 3);
        run_instr(unk,      0, 0, 0, 3);
        run_instr(I_BRANCH, 0, 0, 0, 4);
        run_instr(I_BZERO,  1, 0, 0, 4);
        run_instr(I_BZERO,  0, 0, 0, -1);
        run_instr(I_BNZERO, 0, 0, 0, -1);
        run_instr(I_BNEG,   0, 1, 0, -1);
        run_instr(I_BNNEG,  0, 1, 0, -1);
        run_instr(I_BOV,    0, 0, 1, -1);
        run_instr(I_BNOV,   0, 0, 1, -1);
        run_instr(I_BNOV,   0, 0, 0, -1);

        // Reset landing on the EXEC_STORE cycle must suppress the RAM write
        instr = I_STORE;
        model_front();
        drain();
        do_reset(1);
        run_instr(I_ADD, 0, 0, 0, 4);

        // Halt is sticky for 20 cycles even with a new opcode presented
        instr = I_HALT;
        model_front();
        drain();
        instr = I_ADD;
        for (int c = 0; c < 20; c++) push(v(1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0));
        drain();
        do_reset(1);
        run_instr(I_NOP, 0, 0, 0, 3);
        run_instr(I_OR,  0, 0, 0, 4);

`ifdef K_AND_S_PERF_CNT_EN
        do_reset(1);
        run_instr(I_NOP, 0, 0, 0, -1);
        run_instr(I_NOP, 0, 0, 0, -1);
        run_instr(I_NOP, 0, 0, 0, -1);
        check("instr_count", ic1, 3);
        check("cycle_count", cc1, 9);
`endif

        // MEM_WAIT=3 instance
        sel3 = 1'b1;
        mw = 3;
        do_reset(1);
        run_instr(I_LOAD,  0, 0, 0, 9);
        run_instr(I_ADD,   0, 0, 0, 6);
        run_instr(I_STORE, 0, 0, 0, 6);
        run_instr(I_BZERO, 1, 0, 0, 6);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
